vram_readback_check_m: RTL and testbench
========================================

VRAM_READBACK_CHECK_M -- requirements
Module: vram_readback_check_m

Interface
REQ-001 SHALL have parameter VRAM_ADDR_WIDTH, default 12, VRAM address width.
REQ-002 SHALL have parameter VRAM_SIZE, default 2304 (12'h900), number of VRAM bytes checked.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse; same pulse that starts the VRAM fill sequencer.
REQ-006 SHALL have port wr_data  input  8  fill-sequencer write data.
REQ-007 SHALL have port wr_address  input  VRAM_ADDR_WIDTH  fill-sequencer write address.
REQ-008 SHALL have port wr_enable  input  1  fill-sequencer write strobe.
REQ-009 SHALL have port rd_address  output  VRAM_ADDR_WIDTH  VRAM read address.
REQ-010 SHALL have port rd_enable  output  1  VRAM read strobe.
REQ-011 SHALL have port rd_data  input  8  VRAM read data, valid exactly 1 cycle after rd_enable.
REQ-012 SHALL have port busy  output  1  high in CAPTURE, READ and DRAIN.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port pass  output  1  check result, meaningful only while done=1.
REQ-015 SHALL have port order_error  output  1  sticky out-of-sequence write flag.
REQ-016 SHALL have port wr_sum  output  16  Fletcher-16 of captured writes, {sum2,sum1}.
REQ-017 SHALL have port rd_sum  output  16  Fletcher-16 of readback bytes, {sum2,sum1}.
REQ-018 SHALL have port wr_count  output  13  number of captured writes, saturating at 8191.

Function
REQ-019 SHALL implement states IDLE, CAPTURE, READ, DRAIN, DONE.
REQ-020 SHALL, on start in any state, clear wr_sum, rd_sum, wr_count, order_error and the expected-address counter, then enter CAPTURE next cycle; start has priority over every other transition.
REQ-021 SHALL, in CAPTURE, on each cycle with wr_enable=1: update wr_sum with wr_data, increment wr_count, compare wr_address to the expected counter, set order_error on mismatch, then increment the expected counter.
REQ-022 SHALL leave CAPTURE for READ on the first cycle with wr_enable=0 after at least one write has been captured; wr_enable=0 before any write keeps CAPTURE.
REQ-023 SHALL, in READ, drive rd_enable=1 and rd_address=0,1,...,VRAM_SIZE-1 on consecutive cycles, one address per cycle, then enter DRAIN.
REQ-024 SHALL accumulate rd_data into rd_sum on each cycle following a cycle with rd_enable=1, including the single DRAIN cycle.
REQ-025 SHALL enter DONE after DRAIN, giving done=1 exactly VRAM_SIZE+1 cycles after READ entry.
REQ-026 SHALL drive pass=1 in DONE iff wr_sum==rd_sum, wr_count==VRAM_SIZE and order_error=0; otherwise pass=0.
REQ-027 SHALL hold DONE and all result outputs until start or rst.
REQ-028 SHALL ignore wr_enable outside CAPTURE.
REQ-029 SHALL compute Fletcher-16 per byte b as sum1'=(sum1+b) mod 255, then sum2'=(sum2+sum1') mod 255, using 9-bit intermediates with a conditional subtract of 255, so each half stays in 0..254.
REQ-030 SHALL drive rd_enable=0 and rd_address=0 in every state except READ.
REQ-031 SHALL drive pass=0 outside DONE.

Reset
REQ-032 SHALL, while rst=1, asynchronously force state=IDLE and every output to 0, including mid-CAPTURE or mid-READ.
REQ-033 SHALL remain in IDLE after rst deasserts until start.

Verification
REQ-034 SHALL be verified with a fill of 2304 ascending zero bytes and a memory model returning zeros -> wr_sum=rd_sum=16'h0000, wr_count=2304, order_error=0, done=1 and pass=1 at READ entry+2305 cycles.
REQ-035 SHALL be verified with a full ascending fill of known data and a memory model corrupting address 12'h3C0 -> wr_sum!=rd_sum, pass=0.
REQ-036 SHALL be verified with writes 8'h01 at address 0 then 8'h02 at address 2 -> order_error=1, wr_sum=16'h0403, pass=0.
REQ-037 SHALL be verified with writes 8'hFF then 8'h01 -> wr_sum=16'h0101 (mod-255 wrap).
REQ-038 SHALL be verified by asserting rst for 1 cycle mid-READ -> all outputs 0 immediately, IDLE until start.
REQ-039 SHALL be verified by pulsing start mid-READ -> rd_enable=0 next cycle, sums and wr_count cleared, and a fresh capture that completes normally.

Source files
------------

// File: rtl/vram_readback_check_m.sv
// VRAM readback checker: captures the fill sequencer's write stream into a Fletcher-16
// checksum, reads the whole VRAM back and compares the readback checksum with it.
module vram_readback_check_m #(
    parameter int VRAM_ADDR_WIDTH = 12,
    parameter int VRAM_SIZE       = 2304
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 wr_data,
    input  logic [VRAM_ADDR_WIDTH-1:0] wr_address,
    input  logic                       wr_enable,
    output logic [VRAM_ADDR_WIDTH-1:0] rd_address,
    output logic                       rd_enable,
    input  logic [7:0]                 rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       order_error,
    output logic [15:0]                wr_sum,
    output logic [15:0]                rd_sum,
    output logic [12:0]                wr_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [VRAM_ADDR_WIDTH-1:0] LAST_ADDR = VRAM_ADDR_WIDTH'(VRAM_SIZE - 1);
    localparam logic [12:0]                FULL_COUNT = 13'(VRAM_SIZE);

    logic [2:0]                 r_state;
    logic [VRAM_ADDR_WIDTH-1:0] r_exp_addr;
    logic [VRAM_ADDR_WIDTH-1:0] r_rd_addr;
    logic                       r_rd_pending;
    logic [15:0]                r_wr_sum;
    logic [15:0]                r_rd_sum;
    logic [12:0]                r_wr_count;
    logic                       r_order_error;
    logic                       w_in_read;

    // Fletcher-16 step: each half kept in 0..254 via a single conditional subtract.
    function automatic logic [15:0] f_fletcher(input logic [15:0] sum, input logic [7:0] b);
        logic [8:0] s1;
        logic [8:0] s2;
        s1 = {1'b0, sum[7:0]} + {1'b0, b};
        if (s1 >= 9'd255) s1 = s1 - 9'd255;
        s2 = {1'b0, sum[15:8]} + s1;
        if (s2 >= 9'd255) s2 = s2 - 9'd255;
        return {s2[7:0], s1[7:0]};
    endfunction

    assign w_in_read = (r_state == S_READ);

    // Control FSM, write-stream capture and readback accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_exp_addr    <= '0;
            r_rd_addr     <= '0;
            r_rd_pending  <= 1'b0;
            r_wr_sum      <= '0;
            r_rd_sum      <= '0;
            r_wr_count    <= '0;
            r_order_error <= 1'b0;
        end else if (start) begin
            // Restart from any state; an in-flight read beat is dropped with the old sum.
            r_state       <= S_CAPTURE;
            r_exp_addr    <= '0;
            r_rd_addr     <= '0;
            r_rd_pending  <= 1'b0;
            r_wr_sum      <= '0;
            r_rd_sum      <= '0;
            r_wr_count    <= '0;
            r_order_error <= 1'b0;
        end else begin
            // Read data arrives one cycle after the strobe, so DRAIN takes the last byte.
            r_rd_pending <= w_in_read;
            if (r_rd_pending) r_rd_sum <= f_fletcher(r_rd_sum, rd_data);
            case (r_state)
                S_CAPTURE: begin
                    if (wr_enable) begin
                        r_wr_sum <= f_fletcher(r_wr_sum, wr_data);
                        if (r_wr_count != 13'h1FFF) r_wr_count <= r_wr_count + 13'd1;
                        if (wr_address != r_exp_addr) r_order_error <= 1'b1;
                        r_exp_addr <= r_exp_addr + 1'b1;
                    end else if (r_wr_count != 13'd0) begin
                        r_state   <= S_READ;
                        r_rd_addr <= '0;
                    end
                end
                S_READ: begin
                    if (r_rd_addr == LAST_ADDR) r_state <= S_DRAIN;
                    else r_rd_addr <= r_rd_addr + 1'b1;
                end
                S_DRAIN: r_state <= S_DONE;
                S_IDLE, S_DONE: r_state <= r_state;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state so reset clears them without waiting for a clock.
    always_comb begin
        rd_enable   = w_in_read;
        rd_address  = w_in_read ? r_rd_addr : '0;
        busy        = (r_state == S_CAPTURE) || w_in_read || (r_state == S_DRAIN);
        done        = (r_state == S_DONE);
        pass        = done && (r_wr_sum == r_rd_sum) && (r_wr_count == FULL_COUNT) &&
                      !r_order_error;
        order_error = r_order_error;
        wr_sum      = r_wr_sum;
        rd_sum      = r_rd_sum;
        wr_count    = r_wr_count;
    end

endmodule

// File: tb/tb_vram_readback_check_m.sv
// Scoreboard bench for vram_readback_check_m: stimulus pushes expected results,
// a negedge monitor pops and compares them when done rises.
module tb_vram_readback_check_m;

    localparam int AW = 12;
    localparam int N  = 2304;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  wr_data;
    logic [11:0] wr_address;
    logic        wr_enable;
    logic [11:0] rd_address;
    logic        rd_enable;
    logic [7:0]  rd_data = 8'h00;
    logic        busy, done, pass, order_error;
    logic [15:0] wr_sum, rd_sum;
    logic [12:0] wr_count;

    vram_readback_check_m #(.VRAM_ADDR_WIDTH(AW), .VRAM_SIZE(N)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_data(wr_data), .wr_address(wr_address),
        .wr_enable(wr_enable), .rd_address(rd_address), .rd_enable(rd_enable),
        .rd_data(rd_data), .busy(busy), .done(done), .pass(pass),
        .order_error(order_error), .wr_sum(wr_sum), .rd_sum(rd_sum), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] wsum;
        logic [15:0] rsum;
        logic [12:0] cnt;
        logic        oe;
        logic        ps;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [7:0]  mem [0:4095];
    logic        corrupt = 1'b0;
    logic [15:0] exp_wr;

    // VRAM model: one-cycle read latency, optional corruption of one address.
    always @(posedge clk) begin
        if (rd_enable) begin
            if (corrupt && rd_address == 12'h3C0) rd_data <= mem[rd_address] ^ 8'h5A;
            else rd_data <= mem[rd_address];
        end
    end

    function automatic logic [15:0] fl(input logic [15:0] s, input logic [7:0] b);
        int a;
        int c;
        a = (int'(s[7:0]) + int'(b)) % 255;
        c = (int'(s[15:8]) + a) % 255;
        return {c[7:0], a[7:0]};
    endfunction

    function automatic logic [15:0] rd_model();
        logic [15:0] s;
        logic [7:0]  b;
        s = 16'h0000;
        for (int i = 0; i < N; i++) begin
            b = mem[i];
            if (corrupt && i == 'h3C0) b = b ^ 8'h5A;
            s = fl(s, b);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_wr = 16'h0000;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        wr_enable  = 1'b1;
        wr_address = a;
        wr_data    = d;
        mem[a]     = d;
        exp_wr     = fl(exp_wr, d);
        tick();
    endtask

    task automatic wr_stop();
        wr_enable = 1'b0;
        wr_data   = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 6000) begin
            tick();
            k++;
        end
        if (!done) check({name, "_done_timeout"}, 32'(done), 32'd1);
        repeat (3) tick();
    endtask

    task automatic wait_read(input string name);
        int k;
        k = 0;
        while (!rd_enable && k < 100) begin
            tick();
            k++;
        end
        if (!rd_enable) check({name, "_read_timeout"}, 32'(rd_enable), 32'd1);
    endtask

    task automatic push(input logic [15:0] w, input logic [15:0] r, input logic [12:0] c,
                        input logic oe, input logic ps);
        exp_t e;
        e.wsum = w; e.rsum = r; e.cnt = c; e.oe = oe; e.ps = ps; e.lat = N + 1;
        sbq.push_back(e);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_pass"}, 32'(pass), 0);
        check({name, "_rd_enable"}, 32'(rd_enable), 0);
        check({name, "_rd_address"}, 32'(rd_address), 0);
        check({name, "_order_error"}, 32'(order_error), 0);
        check({name, "_wr_sum"}, 32'(wr_sum), 0);
        check({name, "_rd_sum"}, 32'(rd_sum), 0);
        check({name, "_wr_count"}, 32'(wr_count), 0);
    endtask

    // Monitor: latency measured from the first READ cycle to done rising.
    int   lat_cnt = 0;
    logic done_prev = 1'b0;
    logic rde_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            lat_cnt   = 0;
            done_prev = 1'b0;
            rde_prev  = 1'b0;
        end else begin
            if (rd_enable && !rde_prev) lat_cnt = 0;
            else lat_cnt++;
            if (done && !done_prev) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("sb_wr_sum", 32'(wr_sum), 32'(e.wsum));
                    check("sb_rd_sum", 32'(rd_sum), 32'(e.rsum));
                    check("sb_wr_count", 32'(wr_count), 32'(e.cnt));
                    check("sb_order_error", 32'(order_error), 32'(e.oe));
                    check("sb_pass", 32'(pass), 32'(e.ps));
                    check("sb_latency", 32'(lat_cnt), 32'(e.lat));
                    check("sb_busy", 32'(busy), 32'd0);
                end
            end
            done_prev = done;
            rde_prev  = rd_enable;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; wr_enable = 1'b0; wr_data = 8'h00; wr_address = 12'h000;
        exp_wr = 16'h0000;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);

        // Zero fill, zero memory: pass.
        do_start();
        for (int i = 0; i < N; i++) wr(12'(i), 8'h00);
        wr_stop();
        push(16'h0000, 16'h0000, 13'd2304, 1'b0, 1'b1);
        wait_done("zero");
        repeat (5) tick();
        check("zero_hold_done", 32'(done), 1);
        check("zero_hold_pass", 32'(pass), 1);

        // Known data, corrupted readback at 0x3C0: fail.
        do_start();
        for (int i = 0; i < N; i++) wr(12'(i), 8'(i * 37 + (i >> 5)));
        wr_stop();
        corrupt = 1'b1;
        push(exp_wr, rd_model(), 13'd2304, 1'b0, 1'b0);
        wait_done("corrupt");
        check("corrupt_sums_differ", 32'(wr_sum != rd_sum), 1);
        corrupt = 1'b0;

        // Idle cycles before first write keep CAPTURE; skipped address sets order_error.
        do_start();
        repeat (3) tick();
        check("capture_wait_busy", 32'(busy), 1);
        check("capture_wait_rd_enable", 32'(rd_enable), 0);
        wr(12'h000, 8'h01);
        wr(12'h002, 8'h02);
        wr_stop();
        push(16'h0403, rd_model(), 13'd2, 1'b1, 1'b0);
        wait_done("order");

        // Mod-255 wrap.
        do_start();
        wr(12'h000, 8'hFF);
        wr(12'h001, 8'h01);
        wr_stop();
        push(16'h0101, rd_model(), 13'd2, 1'b0, 1'b0);
        wait_done("wrap");

        // One-cycle reset mid-READ.
        do_start();
        wr(12'h000, 8'h05);
        wr_stop();
        wait_read("rst_mid");
        repeat (10) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();
        check("rst_idle_busy", 32'(busy), 0);
        check("rst_idle_done", 32'(done), 0);
        check("rst_idle_rd_enable", 32'(rd_enable), 0);

        // Restart mid-READ, then a full clean run.
        do_start();
        wr(12'h000, 8'h09);
        wr_stop();
        wait_read("restart");
        repeat (10) tick();
        do_start();
        check("restart_rd_enable", 32'(rd_enable), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_wr_sum", 32'(wr_sum), 0);
        check("restart_rd_sum", 32'(rd_sum), 0);
        check("restart_wr_count", 32'(wr_count), 0);
        for (int i = 0; i < N; i++) wr(12'(i), 8'(i ^ (i >> 4) ^ 8'hA5));
        wr_stop();
        push(exp_wr, rd_model(), 13'd2304, 1'b0, 1'b1);
        wait_done("restart");

        repeat (3) tick();
        check("sb_leftover", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
